slcorem0_ahb_resp_ram: RTL and testbench

//  AHB-Lite responder (slave end) for the Cortex-M0 subsystem's AHB-Lite master port: a small

---
 rtl/slcorem0_ahb_resp_ram.sv | 179 +++++++++++++++++
 tb/tb_slcorem0_ahb_resp_ram.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slcorem0_ahb_resp_ram.sv
// AHB-Lite responder backed by a small flop word RAM: programmable OKAY wait states,
// little-endian byte/halfword/word write lanes and the two-cycle ERROR response.
module slcorem0_ahb_resp_ram #(
    parameter int MEM_WORDS   = 64,
    parameter int WAIT_STATES = 0,
    parameter bit RESET_MEM   = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            dph_q, dph_d;
    logic [AW-1:0]   addrWord_q, addrWord_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            write_q, write_d;

    logic [31:0]     mem_q [MEM_WORDS];

    logic            acc;
    logic            outOfRange;
    logic            sizeErr;
    logic            alignErr;
    logic            reqErr;
    logic            finalCycle;
    logic            memWe;
    logic [3:0]      laneEn;
    logic [31:0]     curWord;
    logic [31:0]     wrWord;
    logic            unusedBits;

    assign acc        = HSEL & HTRANS[1] & HREADY;
    assign outOfRange = ({2'b00, HADDR[31:2]} >= 32'(MEM_WORDS));
    assign sizeErr    = (HSIZE > 3'd2);
    assign alignErr   = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign reqErr     = outOfRange | sizeErr | alignErr;
    assign unusedBits = HTRANS[0];

    // dph_q marks an accepted OKAY transfer whose data phase is in progress;
    // its last cycle is the one spent back in IDLE with HREADYOUT high.
    assign finalCycle = dph_q && (state_q == ST_IDLE);
    assign memWe      = finalCycle && write_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dph_q      <= 1'b0;
            addrWord_q <= '0;
            off_q      <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dph_q      <= dph_d;
            addrWord_q <= addrWord_d;
            off_q      <= off_d;
            size_q     <= size_d;
            write_q    <= write_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dph_d      = dph_q;
        addrWord_d = addrWord_q;
        off_d      = off_q;
        size_d     = size_q;
        write_d    = write_q;

        case (state_q)
            // ERR2 already drives HREADYOUT high, so a new address phase is taken as from IDLE
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (finalCycle) begin
                    dph_d = 1'b0;
                end
                if (acc) begin
                    addrWord_d = HADDR[AW+1:2];
                    off_d      = HADDR[1:0];
                    size_d     = HSIZE[1:0];
                    write_d    = HWRITE;
                    if (reqErr) begin
                        state_d = ST_ERR1;
                        dph_d   = 1'b0;
                    end else begin
                        dph_d = 1'b1;
                        if (HAS_WAIT) begin
                            state_d = ST_WAIT;
                            cnt_d   = WAIT_INIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        laneEn = 4'b0000;
        case (size_q)
            2'd0:    laneEn[off_q] = 1'b1;
            2'd1:    laneEn = off_q[1] ? 4'b1100 : 4'b0011;
            default: laneEn = 4'b1111;
        endcase
    end

    assign curWord = mem_q[addrWord_q];

    always_comb begin
        wrWord = curWord;
        for (int b = 0; b < 4; b++) begin
            if (laneEn[b]) begin
                wrWord[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    if (RESET_MEM) begin : gMemRst
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
                for (int i = 0; i < MEM_WORDS; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (memWe) begin
                mem_q[addrWord_q] <= wrWord;
            end
        end
    end else begin : gMemNoRst
        always_ff @(posedge HCLK) begin
            if (memWe) begin
                mem_q[addrWord_q] <= wrWord;
            end
        end
    end

    assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA    = (dph_q && !write_q) ? curWord : 32'h0000_0000;

endmodule

// File: tb/tb_slcorem0_ahb_resp_ram.sv
// Directed bench for slcorem0_ahb_resp_ram: three instances (0, 2 and 3 wait states)
// share one AHB master model; each scenario task checks its own hand-computed results.
module tb_slcorem0_ahb_resp_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic        busSel;
    int          dutSel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hreadyForce;

    logic        hsel0, hsel2, hsel3;
    logic        rdyIn0, rdyIn2, rdyIn3;
    logic        rdy0, rdy2, rdy3;
    logic        resp0, resp2, resp3;
    logic [31:0] rdata0, rdata2, rdata3;

    logic        curReady;
    logic        curResp;
    logic [31:0] curRdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign hsel0  = busSel && (dutSel == 0);
    assign hsel2  = busSel && (dutSel == 2);
    assign hsel3  = busSel && (dutSel == 3);
    assign rdyIn0 = rdy0 & hreadyForce;
    assign rdyIn2 = rdy2;
    assign rdyIn3 = rdy3;

    slcorem0_ahb_resp_ram #(.MEM_WORDS(64), .WAIT_STATES(0), .RESET_MEM(1'b1)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdyIn0),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
    );

    slcorem0_ahb_resp_ram #(.MEM_WORDS(64), .WAIT_STATES(2), .RESET_MEM(1'b0)) dut2 (
        .HCLK(clk), .HRESET(rst2), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdyIn2),
        .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2)
    );

    slcorem0_ahb_resp_ram #(.MEM_WORDS(64), .WAIT_STATES(3), .RESET_MEM(1'b1)) dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdyIn3),
        .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
    );

    // Outputs of whichever instance the master is currently talking to
    always_comb begin
        curReady = rdy0;
        curResp  = resp0;
        curRdata = rdata0;
        case (dutSel)
            2: begin curReady = rdy2; curResp = resp2; curRdata = rdata2; end
            3: begin curReady = rdy3; curResp = resp3; curRdata = rdata3; end
            default: ;
        endcase
    end

    // Single non-pipelined transfer: address phase, then data phase until HREADYOUT is high.
    // Returns to the caller at the negedge of the final data cycle.
    task automatic xfer(input int sel, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int stalls,
                        output logic resp, output logic stallResp);
        logic done;
        @(posedge clk); #1;
        dutSel = sel; busSel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = wdata;
        stalls = 0; done = 1'b0; stallResp = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge clk);
            if (curReady) done = 1'b1;
            else begin
                stalls++;
                if (curResp) stallResp = 1'b1;
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("[TB] FAIL xfer_timeout addr=%h got=no HREADYOUT exp=HREADYOUT within 32 cycles", addr);
        end
        rdata = curRdata;
        resp  = curResp;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1)  begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", rdy0); end
        checks++; if (resp0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp got=%b exp=0", resp0); end
        checks++; if (rdata0 !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata0); end
        checks++; if (rdy3 !== 1'b1 || resp3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ws3 got=%b%b exp=10", rdy3, resp3); end
    endtask

    task automatic test_word_rw();
        @(posedge clk); #1;
        dutSel = 0; busSel = 1'b1; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'hDEAD_BEEF; haddr = 32'h0; hwrite = 1'b0; htrans = 2'b10;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1) begin failures++; $display("[TB] FAIL word_wr_nostall got=%b exp=1", rdy0); end
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        checks++; if (rdata0 !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL word_rd_data got=%h exp=deadbeef", rdata0); end
        checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin failures++; $display("[TB] FAIL word_rd_okay got=%b%b exp=10", rdy0, resp0); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        int          st;
        logic        rs, srs;
        xfer(0, 32'h05, 1'b1, 3'd0, 32'hAAAA_AAAA, rd, st, rs, srs);
        checks++; if (st != 0 || rs !== 1'b0) begin failures++; $display("[TB] FAIL byte_wr_okay got=stalls %0d resp %b exp=stalls 0 resp 0", st, rs); end
        xfer(0, 32'h06, 1'b1, 3'd1, 32'h1234_1234, rd, st, rs, srs);
        xfer(0, 32'h04, 1'b0, 3'd2, 32'h0, rd, st, rs, srs);
        checks++; if (rd !== 32'h1234_AA00) begin failures++; $display("[TB] FAIL byte_half_merge got=%h exp=1234aa00", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        int          st;
        logic        rs, srs;
        xfer(3, 32'h08, 1'b1, 3'd2, 32'hA5A5_0003, rd, st, rs, srs);
        checks++; if (st != 3) begin failures++; $display("[TB] FAIL ws3_write_stalls got=%0d exp=3", st); end
        xfer(3, 32'h08, 1'b0, 3'd2, 32'h0, rd, st, rs, srs);
        checks++; if (st != 3) begin failures++; $display("[TB] FAIL ws3_read_stalls got=%0d exp=3", st); end
        checks++; if (srs !== 1'b0 || rs !== 1'b0) begin failures++; $display("[TB] FAIL ws3_resp got=stall %b final %b exp=0 0", srs, rs); end
        checks++; if (rd !== 32'hA5A5_0003) begin failures++; $display("[TB] FAIL ws3_read_data got=%h exp=a5a50003", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        int          st;
        logic        rs, srs;
        @(posedge clk); #1;
        dutSel = 0; busSel = 1'b1; haddr = 32'h102; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b0 || resp0 !== 1'b1 || rdata0 !== 32'h0) begin failures++; $display("[TB] FAIL err_wr_err1 got=%b%b %h exp=01 0", rdy0, resp0, rdata0); end
        @(posedge clk); #1;
        haddr = 32'h100; htrans = 2'b10; hwrite = 1'b0;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b1) begin failures++; $display("[TB] FAIL err_wr_err2 got=%b%b exp=11", rdy0, resp0); end
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b0 || resp0 !== 1'b1 || rdata0 !== 32'h0) begin failures++; $display("[TB] FAIL err_rd_err1 got=%b%b %h exp=01 0", rdy0, resp0, rdata0); end
        @(posedge clk); #1;
        haddr = 32'h0; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b1 || rdata0 !== 32'h0) begin failures++; $display("[TB] FAIL err_rd_err2 got=%b%b %h exp=11 0", rdy0, resp0, rdata0); end
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL err2_accept got=%b%b %h exp=10 deadbeef", rdy0, resp0, rdata0); end
        xfer(0, 32'h002, 1'b1, 3'd2, 32'hFFFF_FFFF, rd, st, rs, srs);
        checks++; if (st != 1 || srs !== 1'b1 || rs !== 1'b1) begin failures++; $display("[TB] FAIL err_misalign_word got=stalls %0d resp %b%b exp=stalls 1 resp 11", st, srs, rs); end
        xfer(0, 32'h005, 1'b1, 3'd1, 32'hFFFF_FFFF, rd, st, rs, srs);
        checks++; if (rs !== 1'b1) begin failures++; $display("[TB] FAIL err_misalign_half got=%b exp=1", rs); end
        xfer(0, 32'h004, 1'b1, 3'd3, 32'hFFFF_FFFF, rd, st, rs, srs);
        checks++; if (rs !== 1'b1) begin failures++; $display("[TB] FAIL err_bad_size got=%b exp=1", rs); end
        xfer(0, 32'h000, 1'b0, 3'd2, 32'h0, rd, st, rs, srs);
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL err_mem_word0 got=%h exp=deadbeef", rd); end
        xfer(0, 32'h004, 1'b0, 3'd2, 32'h0, rd, st, rs, srs);
        checks++; if (rd !== 32'h1234_AA00) begin failures++; $display("[TB] FAIL err_mem_word1 got=%h exp=1234aa00", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int          st;
        logic        rs, srs;
        @(posedge clk); #1;
        dutSel = 0; busSel = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10; htrans = 2'b10;
        @(posedge clk); #1;
        hwdata = 32'h11; haddr = 32'h1C; htrans = 2'b01;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_wr0_ready got=%b exp=1", rdy0); end
        @(posedge clk); #1;
        hwdata = 32'hBAD0_BAD0; haddr = 32'h14; htrans = 2'b11;
        @(posedge clk); #1;
        hwdata = 32'h22; haddr = 32'h1C; htrans = 2'b01;
        @(posedge clk); #1;
        hwdata = 32'hBAD1_BAD1; haddr = 32'h18; htrans = 2'b11;
        @(posedge clk); #1;
        hwdata = 32'h33; htrans = 2'b00;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_wr2_okay got=%b%b exp=10", rdy0, resp0); end
        @(posedge clk); #1;
        hwrite = 1'b0; haddr = 32'h10; htrans = 2'b10;
        @(posedge clk); #1;
        haddr = 32'h14; htrans = 2'b11;
        @(negedge clk);
        checks++; if (rdata0 !== 32'h11) begin failures++; $display("[TB] FAIL b2b_rd0 got=%h exp=00000011", rdata0); end
        @(posedge clk); #1;
        haddr = 32'h18; htrans = 2'b11;
        @(negedge clk);
        checks++; if (rdata0 !== 32'h22) begin failures++; $display("[TB] FAIL b2b_rd1 got=%h exp=00000022", rdata0); end
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        checks++; if (rdata0 !== 32'h33) begin failures++; $display("[TB] FAIL b2b_rd2 got=%h exp=00000033", rdata0); end
        xfer(0, 32'h1C, 1'b0, 3'd2, 32'h0, rd, st, rs, srs);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL b2b_busy_no_write got=%h exp=0", rd); end
    endtask

    task automatic test_hready_low();
        logic [31:0] rd;
        int          st;
        logic        rs, srs;
        @(posedge clk); #1;
        dutSel = 0; busSel = 1'b1; hreadyForce = 1'b0;
        haddr = 32'h24; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hreadyForce = 1'b1; htrans = 2'b00; hwdata = 32'h5A5A_5A5A;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1 || rdata0 !== 32'h0) begin failures++; $display("[TB] FAIL hready_low_idle got=%b %h exp=1 0", rdy0, rdata0); end
        xfer(0, 32'h24, 1'b0, 3'd2, 32'h0, rd, st, rs, srs);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL hready_low_no_write got=%h exp=0", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        int          st;
        logic        rs, srs;
        xfer(2, 32'h04, 1'b1, 3'd2, 32'hCAFE_0001, rd, st, rs, srs);
        checks++; if (st != 2) begin failures++; $display("[TB] FAIL ws2_write_stalls got=%0d exp=2", st); end
        @(posedge clk); #1;
        dutSel = 2; busSel = 1'b1; haddr = 32'h04; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (rdy2 !== 1'b0) begin failures++; $display("[TB] FAIL ws2_in_wait got=%b exp=0", rdy2); end
        rst2 = 1'b1;
        @(negedge clk);
        checks++; if (rdy2 !== 1'b1 || resp2 !== 1'b0 || rdata2 !== 32'h0) begin failures++; $display("[TB] FAIL reset_mid_wait got=%b%b %h exp=10 0", rdy2, resp2, rdata2); end
        rst2 = 1'b0; busSel = 1'b0;
        xfer(2, 32'h04, 1'b0, 3'd2, 32'h0, rd, st, rs, srs);
        checks++; if (rd !== 32'hCAFE_0001) begin failures++; $display("[TB] FAIL reset_abort_write got=%h exp=cafe0001", rd); end
        checks++; if (st != 2) begin failures++; $display("[TB] FAIL ws2_read_stalls got=%0d exp=2", st); end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; busSel = 1'b0; dutSel = 0;
        haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hwdata = '0; hreadyForce = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_word_rw();
        test_byte_half();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_hready_low();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
